multicycle_control_fsm: RTL and testbench

- Control finite-state machine for the multicycle MIPS datapath.
- Sits directly upstream of the instruction-register / register-file / ALU datapath and generates every write enable and mux select it consumes.
- Decodes opcode and funct from the latched instruction, sequences fetch/decode/execute/memory/writeback, and uses the ALU zero flag for branches.
- Also keeps a retired-instruction counter for debug and bench checking.

---
 rtl/mips_ctrl_pkg.sv | 62 ++++++
 rtl/ctrl_decode.sv | 98 +++++++++
 rtl/multicycle_control_fsm.sv | 120 ++++++++++++
 tb/tb_multicycle_control_fsm.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM and the datapath muxes it drives.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'h0,
    S_DECODE    = 4'h1,
    S_MEM_ADDR  = 4'h2,
    S_MEM_READ  = 4'h3,
    S_MEM_WB    = 4'h4,
    S_MEM_WRITE = 4'h5,
    S_EXEC_R    = 4'h6,
    S_R_WB      = 4'h7,
    S_EXEC_I    = 4'h8,
    S_I_WB      = 4'h9,
    S_BRANCH    = 4'hA,
    S_JUMP      = 4'hB,
    S_JAL       = 4'hC,
    S_JR        = 4'hD,
    S_HALT      = 4'hF
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REGA   = 2'b11;

  localparam logic [1:0] REG_DST_RD = 2'b00;
  localparam logic [1:0] REG_DST_RT = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic       ALUA_PC   = 1'b0;
  localparam logic       ALUA_REGA = 1'b1;

  localparam logic [1:0] ALUB_IMM     = 2'b00;
  localparam logic [1:0] ALUB_REGB    = 2'b01;
  localparam logic [1:0] ALUB_FOUR    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational state-to-control decoder; pc_we in BRANCH is the only term that looks at zero.
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_src_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       reg_we_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_cmd_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_src_o     = PC_SRC_ALU;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    reg_we_o     = 1'b0;
    reg_dst_o    = REG_DST_RD;
    mem_to_reg_o = M2R_ALU;
    alu_src_a_o  = ALUA_PC;
    alu_src_b_o  = ALUB_IMM;
    alu_cmd_o    = ALU_ADD;

    case (state_e'(state_i))
      S_FETCH: begin
        ir_we_o     = 1'b1;
        pc_we_o     = 1'b1;
        alu_src_b_o = ALUB_FOUR;
      end
      S_DECODE: alu_src_b_o = ALUB_IMM_SH2;
      S_MEM_ADDR: alu_src_a_o = ALUA_REGA;
      S_MEM_READ: iord_o = 1'b1;
      S_MEM_WB: begin
        reg_we_o     = 1'b1;
        reg_dst_o    = REG_DST_RT;
        mem_to_reg_o = M2R_MEM;
      end
      S_MEM_WRITE: begin
        iord_o   = 1'b1;
        mem_we_o = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_o = ALUA_REGA;
        alu_src_b_o = ALUB_REGB;
        case (funct_i)
          FN_SUB:  alu_cmd_o = ALU_SUB;
          FN_SLT:  alu_cmd_o = ALU_SLT;
          default: alu_cmd_o = ALU_ADD;
        endcase
      end
      S_R_WB: reg_we_o = 1'b1;
      S_EXEC_I: begin
        alu_src_a_o = ALUA_REGA;
        alu_cmd_o   = (opcode_i == OP_XORI) ? ALU_XOR : ALU_ADD;
      end
      S_I_WB: begin
        reg_we_o  = 1'b1;
        reg_dst_o = REG_DST_RT;
      end
      S_BRANCH: begin
        alu_src_a_o = ALUA_REGA;
        alu_src_b_o = ALUB_REGB;
        alu_cmd_o   = ALU_SUB;
        pc_src_o    = PC_SRC_ALUOUT;
        pc_we_o     = ~zero_i;
      end
      S_JUMP: begin
        pc_we_o  = 1'b1;
        pc_src_o = PC_SRC_JUMP;
      end
      S_JAL: begin
        pc_we_o      = 1'b1;
        pc_src_o     = PC_SRC_JUMP;
        reg_we_o     = 1'b1;
        reg_dst_o    = REG_DST_RA;
        mem_to_reg_o = M2R_PC;
      end
      S_JR: begin
        pc_we_o  = 1'b1;
        pc_src_o = PC_SRC_REGA;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control FSM: state register, next-state decode and retired counter.
// Optional ILLEGAL_TRAP_EN: unsupported codes park in HALT and expose an illegal output.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             mem_we,
  output logic             iord,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_cmd,
  output logic [3:0]       state,
`ifdef ILLEGAL_TRAP_EN
  output logic             illegal,
`endif
  output logic [CNT_W-1:0] retired
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_e ILLEGAL_NEXT = S_HALT;
`else
  localparam state_e ILLEGAL_NEXT = S_FETCH;
`endif
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             ir_we_raw, pc_we_raw, mem_we_raw, reg_we_raw;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_ADDI, OP_XORI: state_d = S_EXEC_I;
          OP_BNE:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_SLT: state_d = S_EXEC_R;
              FN_JR:                  state_d = S_JR;
              default:                state_d = ILLEGAL_NEXT;
            endcase
          end
          default: state_d = ILLEGAL_NEXT;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: state_d = S_MEM_WB;
      S_EXEC_R:   state_d = S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
`ifdef ILLEGAL_TRAP_EN
      S_HALT:     state_d = S_HALT;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Every clocked entry into FETCH marks a completed instruction, NOPs included.
  always_comb begin
    retired_d = retired_q;
    if (state_d == S_FETCH) retired_d = retired_q + CNT_ONE;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  ctrl_decode u_decode (
    .state_i      (state_q),
    .opcode_i     (opcode),
    .funct_i      (funct),
    .zero_i       (zero),
    .ir_we_o      (ir_we_raw),
    .pc_we_o      (pc_we_raw),
    .pc_src_o     (pc_src),
    .mem_we_o     (mem_we_raw),
    .iord_o       (iord),
    .reg_we_o     (reg_we_raw),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_cmd_o    (alu_cmd)
  );

  // FETCH normally drives ir_we/pc_we, so enables are masked while reset is held.
  assign ir_we   = ir_we_raw  & ~reset;
  assign pc_we   = pc_we_raw  & ~reset;
  assign mem_we  = mem_we_raw & ~reset;
  assign reg_we  = reg_we_raw & ~reset;
  assign state   = state_q;
  assign retired = retired_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed, table-driven bench for multicycle_control_fsm plus reset and illegal-opcode sequences.
module tb_multicycle_control_fsm;
  import mips_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero;
  logic        ir_we, pc_we, mem_we, iord, reg_we, alu_src_a;
  logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0]  alu_cmd;
  logic [3:0]  state;
  logic [31:0] retired;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .mem_we     (mem_we),
    .iord       (iord),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_cmd    (alu_cmd),
    .state      (state),
`ifdef ILLEGAL_TRAP_EN
    .illegal    (illegal),
`endif
    .retired    (retired)
  );

  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic [3:0]  exp_state;
    logic [16:0] exp_ctrl;
    logic [31:0] exp_ret;
  } vec_t;

  vec_t vecs[$];

  // {ir_we, pc_we, pc_src, mem_we, iord, reg_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_cmd}
  function automatic logic [16:0] mk(logic ir, logic pc, logic [1:0] psrc, logic mw, logic io,
                                     logic rw, logic [1:0] rd, logic [1:0] m2r, logic a,
                                     logic [1:0] b, logic [2:0] alu);
    return {ir, pc, psrc, mw, io, rw, rd, m2r, a, b, alu};
  endfunction

  function automatic logic [16:0] ctrl_now();
    return {ir_we, pc_we, pc_src, mem_we, iord, reg_we, reg_dst, mem_to_reg,
            alu_src_a, alu_src_b, alu_cmd};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic [3:0] st, input logic [16:0] c, input logic [31:0] r);
    vec_t v;
    v.opcode = op; v.funct = fn; v.zero = z; v.exp_state = st; v.exp_ctrl = c; v.exp_ret = r;
    vecs.push_back(v);
  endtask

  logic [16:0] c_fetch, c_decode, c_maddr, c_mread, c_mwb, c_mwrite, c_iwb, c_rwb;
  logic [16:0] c_add, c_sub, c_slt, c_addi, c_xori, c_br_nt, c_br_t, c_j, c_jal, c_jr;

  initial begin
    reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;

    c_fetch  = mk(1, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b10, 3'b000);
    c_decode = mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 3'b000);
    c_maddr  = mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b000);
    c_mread  = mk(0, 0, 2'b00, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000);
    c_mwb    = mk(0, 0, 2'b00, 0, 0, 1, 2'b01, 2'b01, 0, 2'b00, 3'b000);
    c_mwrite = mk(0, 0, 2'b00, 1, 1, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000);
    c_add    = mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 2'b01, 3'b000);
    c_sub    = mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 2'b01, 3'b001);
    c_slt    = mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 2'b01, 3'b011);
    c_rwb    = mk(0, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3'b000);
    c_addi   = mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b000);
    c_xori   = mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b010);
    c_iwb    = mk(0, 0, 2'b00, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 3'b000);
    c_br_nt  = mk(0, 0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 2'b01, 3'b001);
    c_br_t   = mk(0, 1, 2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 2'b01, 3'b001);
    c_j      = mk(0, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000);
    c_jal    = mk(0, 1, 2'b10, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 3'b000);
    c_jr     = mk(0, 1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000);

    // LW: 5 cycles
    add(OP_LW, 6'd0, 0, S_FETCH,    c_fetch,  0);
    add(OP_LW, 6'd0, 0, S_DECODE,   c_decode, 0);
    add(OP_LW, 6'd0, 0, S_MEM_ADDR, c_maddr,  0);
    add(OP_LW, 6'd0, 0, S_MEM_READ, c_mread,  0);
    add(OP_LW, 6'd0, 0, S_MEM_WB,   c_mwb,    0);
    // ADD, SLT, SUB R-type: 4 cycles each
    add(OP_RTYPE, FN_ADD, 0, S_FETCH,  c_fetch,  1);
    add(OP_RTYPE, FN_ADD, 0, S_DECODE, c_decode, 1);
    add(OP_RTYPE, FN_ADD, 0, S_EXEC_R, c_add,    1);
    add(OP_RTYPE, FN_ADD, 0, S_R_WB,   c_rwb,    1);
    add(OP_RTYPE, FN_SLT, 0, S_FETCH,  c_fetch,  2);
    add(OP_RTYPE, FN_SLT, 0, S_DECODE, c_decode, 2);
    add(OP_RTYPE, FN_SLT, 0, S_EXEC_R, c_slt,    2);
    add(OP_RTYPE, FN_SLT, 0, S_R_WB,   c_rwb,    2);
    // SW
    add(OP_SW, 6'd0, 0, S_FETCH,     c_fetch,  3);
    add(OP_SW, 6'd0, 0, S_DECODE,    c_decode, 3);
    add(OP_SW, 6'd0, 0, S_MEM_ADDR,  c_maddr,  3);
    add(OP_SW, 6'd0, 0, S_MEM_WRITE, c_mwrite, 3);
    // ADDI, XORI
    add(OP_ADDI, 6'd0, 0, S_FETCH,  c_fetch,  4);
    add(OP_ADDI, 6'd0, 0, S_DECODE, c_decode, 4);
    add(OP_ADDI, 6'd0, 0, S_EXEC_I, c_addi,   4);
    add(OP_ADDI, 6'd0, 0, S_I_WB,   c_iwb,    4);
    add(OP_XORI, 6'd0, 0, S_FETCH,  c_fetch,  5);
    add(OP_XORI, 6'd0, 0, S_DECODE, c_decode, 5);
    add(OP_XORI, 6'd0, 0, S_EXEC_I, c_xori,   5);
    add(OP_XORI, 6'd0, 0, S_I_WB,   c_iwb,    5);
    // BNE not taken (zero=1) then taken (zero=0)
    add(OP_BNE, 6'd0, 1, S_FETCH,  c_fetch,  6);
    add(OP_BNE, 6'd0, 1, S_DECODE, c_decode, 6);
    add(OP_BNE, 6'd0, 1, S_BRANCH, c_br_nt,  6);
    add(OP_BNE, 6'd0, 0, S_FETCH,  c_fetch,  7);
    add(OP_BNE, 6'd0, 0, S_DECODE, c_decode, 7);
    add(OP_BNE, 6'd0, 0, S_BRANCH, c_br_t,   7);
    // J, JAL, JR
    add(OP_J, 6'd0, 0, S_FETCH,  c_fetch,  8);
    add(OP_J, 6'd0, 0, S_DECODE, c_decode, 8);
    add(OP_J, 6'd0, 0, S_JUMP,   c_j,      8);
    add(OP_JAL, 6'd0, 0, S_FETCH,  c_fetch,  9);
    add(OP_JAL, 6'd0, 0, S_DECODE, c_decode, 9);
    add(OP_JAL, 6'd0, 0, S_JAL,    c_jal,    9);
    add(OP_RTYPE, FN_JR, 0, S_FETCH,  c_fetch,  10);
    add(OP_RTYPE, FN_JR, 0, S_DECODE, c_decode, 10);
    add(OP_RTYPE, FN_JR, 0, S_JR,     c_jr,     10);
    add(OP_RTYPE, FN_SUB, 0, S_FETCH,  c_fetch,  11);
    add(OP_RTYPE, FN_SUB, 0, S_DECODE, c_decode, 11);
    add(OP_RTYPE, FN_SUB, 0, S_EXEC_R, c_sub,    11);
    add(OP_RTYPE, FN_SUB, 0, S_R_WB,   c_rwb,    11);
    // Start of an LW that the reset sequence below interrupts
    add(OP_LW, 6'd0, 0, S_FETCH, c_fetch, 12);

    // Reset state while reset is held
    repeat (2) @(negedge clk);
    #1;
    check("reset state", {28'd0, state}, {28'd0, S_FETCH});
    check("reset enables", {28'd0, ir_we, pc_we, mem_we, reg_we}, 32'd0);
    check("reset retired", retired, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      opcode = vecs[i].opcode;
      funct  = vecs[i].funct;
      zero   = vecs[i].zero;
      #1;
      check($sformatf("v%0d state", i), {28'd0, state}, {28'd0, vecs[i].exp_state});
      check($sformatf("v%0d ctrl", i), {15'd0, ctrl_now()}, {15'd0, vecs[i].exp_ctrl});
      check($sformatf("v%0d retired", i), retired, vecs[i].exp_ret);
      @(negedge clk);
    end

    // Now in DECODE of LW; advance to MEM_READ and reset asynchronously mid-cycle.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre-reset state", {28'd0, state}, {28'd0, S_MEM_READ});
    check("pre-reset retired", retired, 32'd12);
    #1 reset = 1'b1;
    #1;
    check("async reset state", {28'd0, state}, {28'd0, S_FETCH});
    check("async reset retired", retired, 32'd0);
    check("async reset enables", {28'd0, ir_we, pc_we, mem_we, reg_we}, 32'd0);
    @(posedge clk);
    #1;
    check("held reset state", {28'd0, state}, {28'd0, S_FETCH});
    check("held reset enables", {28'd0, ir_we, pc_we, mem_we, reg_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    opcode = 6'b111111;
    funct = 6'd0;
    #1;
    check("post-reset fetch ctrl", {15'd0, ctrl_now()}, {15'd0, c_fetch});
    @(negedge clk);
    #1;
    check("illegal decode state", {28'd0, state}, {28'd0, S_DECODE});
    @(negedge clk);
    #1;
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 10; k++) begin
      check($sformatf("halt%0d state", k), {28'd0, state}, 32'h0000000F);
      check($sformatf("halt%0d illegal", k), {31'd0, illegal}, 32'd1);
      check($sformatf("halt%0d enables", k), {28'd0, ir_we, pc_we, mem_we, reg_we}, 32'd0);
      check($sformatf("halt%0d retired", k), retired, 32'd0);
      @(negedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    check("halt exit state", {28'd0, state}, {28'd0, S_FETCH});
    check("halt exit illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
`else
    check("illegal nop state", {28'd0, state}, {28'd0, S_FETCH});
    check("illegal nop retired", retired, 32'd1);
    @(negedge clk);
    #1;
    check("illegal nop2 decode", {28'd0, state}, {28'd0, S_DECODE});
    check("illegal nop2 ctrl", {15'd0, ctrl_now()}, {15'd0, c_decode});
    @(negedge clk);
    #1;
    check("illegal nop2 state", {28'd0, state}, {28'd0, S_FETCH});
    check("illegal nop2 retired", retired, 32'd2);
    // Unsupported funct under R-type also behaves as a 2-cycle NOP.
    opcode = OP_RTYPE;
    funct  = 6'b111111;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("bad funct state", {28'd0, state}, {28'd0, S_FETCH});
    check("bad funct retired", retired, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
